// File: rtl/job_responder.sv
// Worker end of the start/finish job handshake: accepts a request, runs a sel-scaled timed job, pulses finish.
// Optional: define JOB_RESPONDER_ABORT_EN to let start falling during a job abort it without finish.
module job_responder #(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sel,
    output logic             finish,
    output logic             busy,
    output logic [2:0]       job_id,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       job_id_q, job_id_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] len;

    assign len = (CNT_W'(sel) + CNT_W'(1)) * CNT_W'(UNIT_CYCLES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            job_id_q <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            job_id_q <= job_id_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        job_id_d = job_id_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    job_id_d = sel;
                    rem_d    = len - CNT_W'(1);
                end
            end
            RUN: begin
`ifdef JOB_RESPONDER_ABORT_EN
                if (!start) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
`else
                if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
`endif
            end
            DONE: begin
                rem_d   = '0;
                state_d = start ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
                rem_d = '0;
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                job_id_d = '0;
                rem_d    = '0;
            end
        endcase
    end

    // Moore outputs: decoded from registered state only
    assign busy      = (state_q == RUN);
    assign finish    = (state_q == DONE);
    assign job_id    = job_id_q;
    assign remaining = rem_q;

endmodule

// File: doc/job_responder.md
# job_responder

Worker-side end of the start/finish handshake used by the team's controller FSMs. The controller raises `start` and holds it with a 3-bit `sel`; this block accepts the request, latches `sel`, and runs a timed job whose length is set by `sel`. It then returns a one-cycle `finish` pulse, which tells the controller to drop `start`. It sits beside each controller instance as the job engine it launches.

## Interface
- `UNIT_CYCLES`, default 4: cycles per `sel` step; job length is LEN = (sel+1)*UNIT_CYCLES, and UNIT_CYCLES must be at least 1.
- `CNT_W`, default 8: width of the remaining-cycle counter; must satisfy 2^CNT_W > 8*UNIT_CYCLES.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request from the controller; it is held high until `finish` is seen.
- `sel`  in  3  job select; sampled only when a request is accepted.
- `finish`  out  1  one-cycle pulse marking job completion.
- `busy`  out  1  high while a job is counting.
- `job_id`  out  3  `sel` value latched when the request was accepted.
- `remaining`  out  CNT_W  cycles left in the current job; 0 when not running.

## Operation
- States: IDLE, RUN, DONE, WAIT_LOW. All outputs are registered or decoded from the registered state only (Moore outputs).
- IDLE: if `start`=1 at a clock edge, go to RUN, latch `job_id`<=sel and load `remaining`<=LEN-1. Otherwise stay in IDLE.
- RUN: `busy`=1.
  - If `remaining`!=0, decrement by 1.
  - If `remaining`==0, go to DONE.
  - RUN lasts exactly LEN cycles.
- DONE: `finish`=1 for exactly one cycle and `busy`=0.
  - If `start`=0, next state is IDLE.
  - If `start`=1, next state is WAIT_LOW.
- WAIT_LOW: `finish`=0. Stay until `start`=0, then go to IDLE. This prevents a held-high `start` from retriggering a job.
- `sel` changes while in RUN, DONE or WAIT_LOW are ignored.
- Arithmetic: LEN is computed at width CNT_W as ({sel}+1)*UNIT_CYCLES, with no truncation within the legal parameter range. `remaining` never wraps below 0.
- Illegal state encodings recover to IDLE on the next edge, with outputs at reset values.

## Timing
- Reset values: state IDLE, `finish`=0, `busy`=0, `job_id`=0, `remaining`=0. Reset takes effect asynchronously, including in the middle of a job; no `finish` is emitted for a job interrupted by reset.
- Acceptance latency: `start` sampled high at edge 0 gives `busy`=1 from edge 0 through edge LEN-1.
- `finish` is high between edges LEN and LEN+1.
- A new request is accepted no earlier than edge LEN+2, and only when `start` was sampled 0 at DONE or in WAIT_LOW.
- If `start` falls in the same cycle as DONE, the next state is IDLE directly. A `start` sampled high in that IDLE cycle is a new request.
- `rst` deasserting in the same cycle as `start`=1: the request is accepted at the first edge after release.

## Configuration
- `JOB_RESPONDER_ABORT_EN` defined:
  - In RUN, `start` sampled 0 aborts the job: next state is IDLE, `remaining`<=0, `busy`<=0, and no `finish` pulse is emitted.
  - `job_id` keeps its last latched value.
- `JOB_RESPONDER_ABORT_EN` undefined: `start` is ignored in RUN and the job always runs to completion with a `finish` pulse.

## Test plan
- Basic job: UNIT_CYCLES=4, sel=0, `start` rises at edge 0 and drops when `finish` is seen. Require `busy` high for 4 cycles, `remaining` reading 3,2,1,0, `finish` pulse at edge 4, `job_id`=0, and return to IDLE.
- Longest job: sel=7. Require 32 busy cycles, `finish` at edge 32, `job_id`=7. Changing `sel` to 2 mid-job has no effect on length or `job_id`.
- Held start: keep `start` high for 10 cycles after `finish`. Require exactly one `finish` and no second job. Drop `start` for 1 cycle, then raise it with sel=1: a new job of 8 cycles starts.
- Reset mid-job: assert `rst`=0 at cycle 5 of a sel=3 job. Require all outputs at reset values immediately with no `finish`. After release with `start` high, a fresh job is accepted.
- Abort, macro defined: drop `start` at cycle 3 of a sel=2 job. Require IDLE next edge, `busy`=0, `remaining`=0, and no `finish`.
- Same stimulus, macro undefined: the job runs the full 12 cycles and `finish` pulses once.
